nibble_serial_adder_ctrl: RTL



---
 rtl/nibble_serial_adder_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial adder controller: sequences one external 4-bit adder slice
// over a wide operand pair, LSB nibble first, with a Start/Busy/Done handshake.
module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Start,
  input  logic [4*NIBBLES-1:0]   A,
  input  logic [4*NIBBLES-1:0]   B,
  input  logic                   Cin,
  output logic                   Busy,
  output logic                   Done,
  output logic [4*NIBBLES-1:0]   Sum,
  output logic                   Cout,
  output logic                   Ovf,
  output logic [3:0]             AdderX,
  output logic [3:0]             AdderY,
  output logic                   AdderCin,
  input  logic [3:0]             AdderS,
  input  logic                   AdderCout
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    opa_q, opa_d;
  logic [W-1:0]    opb_q, opb_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic            last;
  logic            accept;
  logic [IW+1:0]   sh;

  assign last   = (idx_q == IW'(NIBBLES - 1));
  assign accept = Start && (state_q == S_IDLE || state_q == S_DONE);
  assign sh     = {idx_q, 2'b00};

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: operands, carry, index, accumulator, results
  always_ff @(posedge Clk) begin
    if (Rst) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (Start) state_d = S_RUN;
      S_RUN:  if (last) state_d = S_DONE;
      S_DONE: state_d = Start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: capture on accept, accumulate one nibble per RUN cycle
  always_comb begin
    idx_d   = idx_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (accept) begin
      opa_d   = A;
      opb_d   = B;
      carry_d = Cin;
      idx_d   = '0;
      acc_d   = '0;
    end else if (state_q == S_RUN) begin
      acc_d[sh +: 4] = AdderS;
      carry_d        = AdderCout;
      idx_d          = idx_q + 1'b1;
      if (last) begin
        idx_d  = '0;
        sum_d  = acc_d;
        cout_d = AdderCout;
        ovf_d  = (opa_q[W-1] == opb_q[W-1]) &&
                 (AdderS[3] != opa_q[W-1]);
      end
    end
  end

  // Outputs: handshake from state, adder slice driven only in RUN
  always_comb begin
    Busy     = (state_q == S_RUN);
    Done     = (state_q == S_DONE);
    AdderX   = 4'h0;
    AdderY   = 4'h0;
    AdderCin = 1'b0;
    if (state_q == S_RUN) begin
      AdderX   = opa_q[sh +: 4];
      AdderY   = opb_q[sh +: 4];
      AdderCin = carry_q;
    end
  end

  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;

endmodule
